acl_cmd_sequencer: RTL
======================

Name: acl_cmd_sequencer

Overview:
- Sits directly downstream of the tester FSM.
- Consumes its five ACL2 command strobes (init/start measurement, init/start linked, soft reset) and drives the command-ready handshake back to it.
- Expands each command into a fixed sequence of ADXL362 register writes, issued one at a time to the SPI byte-transaction driver.
- Enforces the ADXL362 power-up and soft-reset settling delays.

Parameters:
- PARAM_SETTLE_CYCLES, 10000, settle wait after reset deassert and after the soft-reset write (0.5 ms at 20 MHz); legal range 1..2^20-1.
- PARAM_THRESH_ACT, 11'd150, activity threshold written to THRESH_ACT_L/H.
- PARAM_THRESH_INACT, 11'd50, inactivity threshold written to THRESH_INACT_L/H.
- PARAM_TIME_INACT, 16'd100, inactivity time written to TIME_INACT_L/H.

Ports:
- i_clk_20mhz  in  1  system clock
- i_rst_20mhz  in  1  reset, synchronous, active-high
- i_acl_cmd_init_measur_mode  in  1  command strobe
- i_acl_cmd_start_measur_mode  in  1  command strobe
- i_acl_cmd_init_linked_mode  in  1  command strobe
- i_acl_cmd_start_linked_mode  in  1  command strobe
- i_acl_cmd_soft_reset  in  1  soft-reset request, may be a 1-cycle pulse
- o_acl_command_ready  out  1  high only when idle and accepting a command
- o_spi_wr_req  out  1  1-cycle pulse: start a 2-byte register write
- o_spi_addr  out  8  ADXL362 register address, stable from req until done
- o_spi_data  out  8  register data, stable from req until done
- i_spi_ready  in  1  SPI driver idle and able to accept a request
- i_spi_done  in  1  1-cycle pulse: current write finished
- o_seq_step  out  4  index of the step in flight within the current sequence, for debug

Behaviour:
Reset (i_rst_20mhz=1):
- Outputs: o_acl_command_ready=0, o_spi_wr_req=0, o_spi_addr=0, o_spi_data=0, o_seq_step=0.
- State goes to ST_SETTLE; the settle counter is loaded with PARAM_SETTLE_CYCLES.
- Reset asserted mid-sequence abandons the sequence silently. The SPI driver is reset by the same signal.

State ST_SETTLE:
- Counter decrements once per cycle. At zero, go to ST_IDLE.
- o_acl_command_ready rises exactly PARAM_SETTLE_CYCLES+1 cycles after reset deasserts.

State ST_IDLE (o_acl_command_ready=1):
- Commands are sampled every cycle.
- Priority when several are high: soft_reset > init_measur > init_linked > start_measur > start_linked.
- A command sampled in cycle N latches the sequence select and step 0 in cycle N, gives o_acl_command_ready=0 in cycle N+1, and moves to ST_ISSUE.

State ST_ISSUE:
- o_spi_addr and o_spi_data are driven from the step ROM.
- When i_spi_ready=1: pulse o_spi_wr_req for one cycle and go to ST_WAIT_DONE.
- While i_spi_ready=0: hold state indefinitely; there is no timeout.

State ST_WAIT_DONE:
- Wait for i_spi_done. i_spi_done seen in any other state is ignored.
- On done: if this was the last step of the sequence, go to ST_SETTLE when the sequence is soft reset, otherwise to ST_IDLE. Else increment the step and return to ST_ISSUE.
- o_acl_command_ready returns to 1 the cycle after the final i_spi_done (non-reset sequences).

Sequences, as (address, data) pairs:
- SOFT_RESET: (0x1F, 0x52), then ST_SETTLE.
- INIT_MEASUR: (0x2D, 0x00), (0x2C, 0x13).
- START_MEASUR: (0x2D, 0x02).
- INIT_LINKED: (0x2D, 0x00), (0x20, thr_act[7:0]), (0x21, {5'b0, thr_act[10:8]}), (0x23, thr_inact[7:0]), (0x24, {5'b0, thr_inact[10:8]}), (0x25, time[7:0]), (0x26, time[15:8]), (0x27, 0x3F), (0x2C, 0x13). Nine steps in total.
- START_LINKED: (0x2D, 0x02).

Soft reset while busy (ST_ISSUE or ST_WAIT_DONE):
- A pending flag is set; the pulse is not lost.
- After the current write's i_spi_done, the remaining steps are abandoned and the SOFT_RESET sequence starts at step 0.
- If the request arrives in ST_ISSUE before o_spi_wr_req is pulsed, the pending write is not issued.
- Soft reset in ST_SETTLE restarts the counter with no SPI write.

Other commands while busy or settling are ignored. The tester FSM keeps them asserted until o_acl_command_ready is seen.

Decomposition:
- Package acl_seq_pkg holds:
  - typedef t_seq_state {ST_SETTLE, ST_IDLE, ST_ISSUE, ST_WAIT_DONE};
  - typedef t_seq_sel (5 sequences);
  - ADXL362 register address constants and the POWER_CTL / FILTER_CTL / ACT_INACT_CTL / soft-reset values;
  - function seq_len(t_seq_sel).
- Sub-module acl_seq_rom: purely combinational (sel, step, parameters) -> (addr, data).

Test Plan:
- Reset released with PARAM_SETTLE_CYCLES=8 -> o_acl_command_ready stays 0 for 8 cycles, is 1 on cycle 9, and no o_spi_wr_req is seen.
- init_measur held, SPI model returns done 40 cycles after each req -> exactly 2 reqs, (0x2D, 0x00) then (0x2C, 0x13); ready is low until 1 cycle after the 2nd done.
- init_linked with default parameters -> 9 writes in order, with 0x20=0x96, 0x21=0x00, 0x23=0x32, 0x25=0x64, 0x26=0x00, 0x27=0x3F; o_seq_step counts 0..8.
- init_measur and start_linked asserted in the same idle cycle -> only (0x2D, 0x00), (0x2C, 0x13) are issued.
- 1-cycle soft_reset pulse during step 3 of INIT_LINKED -> step 3 completes, steps 4..8 are never issued, next write is (0x1F, 0x52), then the settle period, then ready=1.
- i_spi_ready held 0 for 100 cycles in ST_ISSUE -> no req and addr/data stable; req pulses once in the cycle after ready rises. Reset asserted mid-wait -> all outputs reach reset values in the next cycle.

Source files
------------

// File: rtl/acl_seq_pkg.sv
// Shared types and ADXL362 register map for the ACL2 command sequencer.
package acl_seq_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE
  } t_seq_state;

  typedef enum logic [2:0] {
    SEQ_SOFT_RESET,
    SEQ_INIT_MEASUR,
    SEQ_START_MEASUR,
    SEQ_INIT_LINKED,
    SEQ_START_LINKED
  } t_seq_sel;

  // Settle counter width covers the full legal settle range.
  localparam int SETTLE_CNT_W = 20;

  // ADXL362 register addresses
  localparam logic [7:0] REG_SOFT_RESET     = 8'h1F;
  localparam logic [7:0] REG_THRESH_ACT_L   = 8'h20;
  localparam logic [7:0] REG_THRESH_ACT_H   = 8'h21;
  localparam logic [7:0] REG_THRESH_INACT_L = 8'h23;
  localparam logic [7:0] REG_THRESH_INACT_H = 8'h24;
  localparam logic [7:0] REG_TIME_INACT_L   = 8'h25;
  localparam logic [7:0] REG_TIME_INACT_H   = 8'h26;
  localparam logic [7:0] REG_ACT_INACT_CTL  = 8'h27;
  localparam logic [7:0] REG_FILTER_CTL     = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL      = 8'h2D;

  // Register values
  localparam logic [7:0] SOFT_RESET_KEY     = 8'h52;
  localparam logic [7:0] POWER_CTL_STANDBY  = 8'h00;
  localparam logic [7:0] POWER_CTL_MEASURE  = 8'h02;
  localparam logic [7:0] FILTER_CTL_VAL     = 8'h13;
  localparam logic [7:0] ACT_INACT_CTL_VAL  = 8'h3F;

  // Number of register writes making up each sequence.
  function automatic logic [3:0] seq_len(input t_seq_sel sel);
    case (sel)
      SEQ_SOFT_RESET:   return 4'd1;
      SEQ_INIT_MEASUR:  return 4'd2;
      SEQ_START_MEASUR: return 4'd1;
      SEQ_INIT_LINKED:  return 4'd9;
      SEQ_START_LINKED: return 4'd1;
      default:          return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/acl_seq_rom.sv
// Step ROM: maps (sequence, step) to the ADXL362 register write for that step.
module acl_seq_rom
  import acl_seq_pkg::*;
#(
  parameter logic [10:0] PARAM_THRESH_ACT   = 11'd150,
  parameter logic [10:0] PARAM_THRESH_INACT = 11'd50,
  parameter logic [15:0] PARAM_TIME_INACT   = 16'd100
) (
  input  t_seq_sel   sel,
  input  logic [3:0] step,
  output logic [7:0] addr,
  output logic [7:0] data
);

  // Combinational lookup; unused step slots read as zero.
  always_comb begin
    addr = 8'h00;
    data = 8'h00;
    case (sel)
      SEQ_SOFT_RESET: begin
        addr = REG_SOFT_RESET;
        data = SOFT_RESET_KEY;
      end
      SEQ_INIT_MEASUR: begin
        if (step == 4'd0) begin
          addr = REG_POWER_CTL;
          data = POWER_CTL_STANDBY;
        end else begin
          addr = REG_FILTER_CTL;
          data = FILTER_CTL_VAL;
        end
      end
      SEQ_START_MEASUR, SEQ_START_LINKED: begin
        addr = REG_POWER_CTL;
        data = POWER_CTL_MEASURE;
      end
      SEQ_INIT_LINKED: begin
        case (step)
          4'd0: begin addr = REG_POWER_CTL;      data = POWER_CTL_STANDBY; end
          4'd1: begin addr = REG_THRESH_ACT_L;   data = PARAM_THRESH_ACT[7:0]; end
          4'd2: begin addr = REG_THRESH_ACT_H;   data = {5'b0, PARAM_THRESH_ACT[10:8]}; end
          4'd3: begin addr = REG_THRESH_INACT_L; data = PARAM_THRESH_INACT[7:0]; end
          4'd4: begin addr = REG_THRESH_INACT_H; data = {5'b0, PARAM_THRESH_INACT[10:8]}; end
          4'd5: begin addr = REG_TIME_INACT_L;   data = PARAM_TIME_INACT[7:0]; end
          4'd6: begin addr = REG_TIME_INACT_H;   data = PARAM_TIME_INACT[15:8]; end
          4'd7: begin addr = REG_ACT_INACT_CTL;  data = ACT_INACT_CTL_VAL; end
          4'd8: begin addr = REG_FILTER_CTL;     data = FILTER_CTL_VAL; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acl_cmd_sequencer.sv
// ACL2 command sequencer: turns tester-FSM command strobes into ADXL362
// register-write sequences and enforces power-up / soft-reset settling.
module acl_cmd_sequencer
  import acl_seq_pkg::*;
#(
  parameter int unsigned PARAM_SETTLE_CYCLES = 10000,
  parameter logic [10:0] PARAM_THRESH_ACT    = 11'd150,
  parameter logic [10:0] PARAM_THRESH_INACT  = 11'd50,
  parameter logic [15:0] PARAM_TIME_INACT    = 16'd100
) (
  input  logic       i_clk_20mhz,
  input  logic       i_rst_20mhz,
  input  logic       i_acl_cmd_init_measur_mode,
  input  logic       i_acl_cmd_start_measur_mode,
  input  logic       i_acl_cmd_init_linked_mode,
  input  logic       i_acl_cmd_start_linked_mode,
  input  logic       i_acl_cmd_soft_reset,
  output logic       o_acl_command_ready,
  output logic       o_spi_wr_req,
  output logic [7:0] o_spi_addr,
  output logic [7:0] o_spi_data,
  input  logic       i_spi_ready,
  input  logic       i_spi_done,
  output logic [3:0] o_seq_step
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(PARAM_SETTLE_CYCLES);

  t_seq_state              state_q, state_d;
  t_seq_sel                sel_q, sel_d;
  logic [3:0]              step_q, step_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                    srst_pend_q, srst_pend_d;
  logic                    wr_req_q, wr_req_d;
  logic                    last_step;
  logic [7:0]              rom_addr, rom_data;

  acl_seq_rom #(
    .PARAM_THRESH_ACT   (PARAM_THRESH_ACT),
    .PARAM_THRESH_INACT (PARAM_THRESH_INACT),
    .PARAM_TIME_INACT   (PARAM_TIME_INACT)
  ) u_rom (
    .sel  (sel_q),
    .step (step_q),
    .addr (rom_addr),
    .data (rom_data)
  );

  assign last_step = (step_q == (seq_len(sel_q) - 4'd1));

  // State register; reset abandons any sequence and restarts the settle wait.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q      <= ST_SETTLE;
      sel_q        <= SEQ_SOFT_RESET;
      step_q       <= 4'd0;
      settle_cnt_q <= SETTLE_LOAD;
      srst_pend_q  <= 1'b0;
      wr_req_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      step_q       <= step_d;
      settle_cnt_q <= settle_cnt_d;
      srst_pend_q  <= srst_pend_d;
      wr_req_q     <= wr_req_d;
    end
  end

  // Next-state logic: command decode, write issue, and soft-reset preemption.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    step_d       = step_q;
    settle_cnt_d = settle_cnt_q;
    srst_pend_d  = srst_pend_q;
    wr_req_d     = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (i_acl_cmd_soft_reset) begin
          settle_cnt_d = SETTLE_LOAD;
        end else if (settle_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      ST_IDLE: begin
        if (i_acl_cmd_soft_reset || i_acl_cmd_init_measur_mode ||
            i_acl_cmd_init_linked_mode || i_acl_cmd_start_measur_mode ||
            i_acl_cmd_start_linked_mode) begin
          state_d = ST_ISSUE;
          step_d  = 4'd0;
          if (i_acl_cmd_soft_reset)             sel_d = SEQ_SOFT_RESET;
          else if (i_acl_cmd_init_measur_mode)  sel_d = SEQ_INIT_MEASUR;
          else if (i_acl_cmd_init_linked_mode)  sel_d = SEQ_INIT_LINKED;
          else if (i_acl_cmd_start_measur_mode) sel_d = SEQ_START_MEASUR;
          else                                  sel_d = SEQ_START_LINKED;
        end
      end
      ST_ISSUE: begin
        // A soft reset before the request goes out replaces the pending write.
        if (i_acl_cmd_soft_reset || srst_pend_q) begin
          sel_d       = SEQ_SOFT_RESET;
          step_d      = 4'd0;
          srst_pend_d = 1'b0;
        end else if (i_spi_ready) begin
          wr_req_d = 1'b1;
          state_d  = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_acl_cmd_soft_reset) srst_pend_d = 1'b1;
        if (i_spi_done) begin
          if (srst_pend_q || i_acl_cmd_soft_reset) begin
            sel_d       = SEQ_SOFT_RESET;
            step_d      = 4'd0;
            srst_pend_d = 1'b0;
            state_d     = ST_ISSUE;
          end else if (last_step) begin
            if (sel_q == SEQ_SOFT_RESET) begin
              state_d      = ST_SETTLE;
              settle_cnt_d = SETTLE_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            step_d  = step_q + 4'd1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // Outputs: address/data only presented while a write is being set up or in flight.
  always_comb begin
    o_acl_command_ready = (state_q == ST_IDLE);
    o_spi_wr_req        = wr_req_q;
    o_seq_step          = step_q;
    o_spi_addr          = 8'h00;
    o_spi_data          = 8'h00;
    if (state_q == ST_ISSUE || state_q == ST_WAIT_DONE) begin
      o_spi_addr = rom_addr;
      o_spi_data = rom_data;
    end
  end

endmodule
